// File: rtl/data_bus_bridge.sv
// Bridges the core's split load/store data bus onto data RAM and a small MMIO block
// holding a 64-bit machine timer with compare IRQ and a byte-wide UART TX FIFO.
module data_bus_bridge #(
  parameter int unsigned RAM_AW     = 16,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMER_DIV  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       data_raddr,
  input  logic              data_re,
  output logic [31:0]       data_rdata,
  input  logic [31:0]       data_waddr,
  input  logic [31:0]       data_wdata,
  input  logic [3:0]        data_wstrb,
  input  logic              data_we,
  output logic [RAM_AW-1:0] ram_raddr,
  input  logic [31:0]       ram_rdata,
  output logic [RAM_AW-1:0] ram_waddr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wstrb,
  output logic              ram_we,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  output logic              timer_irq,
  output logic              bus_err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DIV_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TIMER_DIV - 1);

  localparam logic [3:0] OFF_MTIME_LO = 4'h0;
  localparam logic [3:0] OFF_MTIME_HI = 4'h1;
  localparam logic [3:0] OFF_CMP_LO   = 4'h2;
  localparam logic [3:0] OFF_CMP_HI   = 4'h3;
  localparam logic [3:0] OFF_TXDATA   = 4'h4;
  localparam logic [3:0] OFF_STATUS   = 4'h5;

  function automatic logic in_ram(input logic [31:0] a);
    return (a >> RAM_AW) == 32'd0;
  endfunction

  function automatic logic in_mmio(input logic [31:0] a);
    return a[31:6] == MMIO_BASE[31:6];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                        input logic [3:0] strb);
    logic [31:0] m;
    m = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) m[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return m;
  endfunction

  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             irq_q, irq_d;
  logic             bus_err_q, bus_err_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       fifo_mem [FIFO_DEPTH];

  logic       rd_ram, rd_mmio, wr_ram, wr_mmio;
  logic [3:0] rd_off, wr_off;
  logic       mmio_store;
  logic       tick;
  logic       wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi;
  logic       fifo_full, fifo_empty;
  logic       push, pop, push_ok, ovf_clr;
  logic [31:0] status_word;

  assign rd_ram  = in_ram(data_raddr);
  assign rd_mmio = ~rd_ram & in_mmio(data_raddr);
  assign wr_ram  = in_ram(data_waddr);
  assign wr_mmio = ~wr_ram & in_mmio(data_waddr);
  assign rd_off  = data_raddr[5:2];
  assign wr_off  = data_waddr[5:2];

  // A store with no byte enables is a no-op everywhere, including tick suppression.
  assign mmio_store  = data_we & wr_mmio & (|data_wstrb);
  assign wr_mtime_lo = mmio_store & (wr_off == OFF_MTIME_LO);
  assign wr_mtime_hi = mmio_store & (wr_off == OFF_MTIME_HI);
  assign wr_cmp_lo   = mmio_store & (wr_off == OFF_CMP_LO);
  assign wr_cmp_hi   = mmio_store & (wr_off == OFF_CMP_HI);

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = mmio_store & (wr_off == OFF_TXDATA) & data_wstrb[0];
  assign pop        = ~fifo_empty & uart_tx_ready;
  assign push_ok    = push & (~fifo_full | pop);
  assign ovf_clr    = mmio_store & (wr_off == OFF_STATUS) & data_wstrb[0] & data_wdata[2];

  assign status_word = {16'h0, 8'(count_q), 5'h0, overflow_q, fifo_empty, fifo_full};

  assign ram_raddr = data_raddr[RAM_AW-1:0];
  assign ram_waddr = data_waddr[RAM_AW-1:0];
  assign ram_wdata = data_wdata;
  assign ram_wstrb = data_wstrb;
  assign ram_we    = data_we & wr_ram & ~rst;

  assign uart_tx_valid = ~fifo_empty;
  assign uart_tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
  assign timer_irq     = irq_q;
  assign bus_err       = bus_err_q;

  always_comb begin
    data_rdata = 32'h0;
    if (data_re) begin
      if (rd_ram) begin
        data_rdata = ram_rdata;
      end else if (rd_mmio) begin
        case (rd_off)
          OFF_MTIME_LO: data_rdata = mtime_q[31:0];
          OFF_MTIME_HI: data_rdata = mtime_q[63:32];
          OFF_CMP_LO:   data_rdata = mtimecmp_q[31:0];
          OFF_CMP_HI:   data_rdata = mtimecmp_q[63:32];
          OFF_STATUS:   data_rdata = status_word;
          default:      data_rdata = 32'h0;
        endcase
      end
    end
  end

  always_comb begin
    tick       = (div_q == DIV_MAX);
    div_d      = tick ? '0 : div_q + 1'b1;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    // Software stores to either mtime word win over the tick for that cycle.
    if (wr_mtime_lo | wr_mtime_hi) begin
      if (wr_mtime_lo) mtime_d[31:0]  = merge(mtime_q[31:0], data_wdata, data_wstrb);
      if (wr_mtime_hi) mtime_d[63:32] = merge(mtime_q[63:32], data_wdata, data_wstrb);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (wr_cmp_lo) mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], data_wdata, data_wstrb);
    if (wr_cmp_hi) mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], data_wdata, data_wstrb);
    irq_d = (mtime_d >= mtimecmp_d);
  end

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    // A dropped byte in the same cycle as a clear leaves overflow set.
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (push && fifo_full && !pop) overflow_d = 1'b1;
    bus_err_d  = bus_err_q
               | (data_re & ~rd_ram & ~rd_mmio)
               | (data_we & ~wr_ram & ~wr_mmio);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      div_q      <= '0;
      irq_q      <= 1'b0;
      bus_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      div_q      <= div_d;
      irq_q      <= irq_d;
      bus_err_q  <= bus_err_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage has no reset; an empty FIFO masks whatever is left in it.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) fifo_mem[wr_ptr_q] <= data_wdata[7:0];
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed bench for data_bus_bridge: loads and UART bytes are checked by a scoreboard monitor.
module tb_data_bus_bridge;

  localparam logic [31:0] M = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_raddr, data_rdata, data_waddr, data_wdata;
  logic        data_re, data_we;
  logic [3:0]  data_wstrb;
  logic [15:0] ram_raddr, ram_waddr;
  logic [31:0] ram_rdata, ram_wdata;
  logic [3:0]  ram_wstrb;
  logic        ram_we;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, uart_tx_ready;
  logic        timer_irq, bus_err;

  always #5 clk = ~clk;

  data_bus_bridge dut (
    .clk(clk), .rst(rst),
    .data_raddr(data_raddr), .data_re(data_re), .data_rdata(data_rdata),
    .data_waddr(data_waddr), .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_we(data_we),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_wstrb(ram_wstrb), .ram_we(ram_we),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .timer_irq(timer_irq), .bus_err(bus_err)
  );

  // Small asynchronous-read RAM behind the bridge.
  logic [31:0] tb_ram [0:255] = '{default: 32'h0};
  assign ram_rdata = tb_ram[ram_raddr[9:2]];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_wstrb[b]) tb_ram[ram_waddr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  typedef struct { logic [31:0] val; string tag; } exp_t;
  exp_t       rd_q[$];
  logic [7:0] uart_q[$];
  exp_t       mon_e;
  logic [7:0] mon_b;

  int n_checks = 0;
  int n_fail   = 0;
  int ram_we_cnt = 0;
  int we_snap;
  logic [3:0]  last_wstrb;
  logic [31:0] last_wdata;
  logic [15:0] last_waddr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (data_re) begin
      if (rd_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_load: got 0x%0h, expected no load", data_rdata);
      end else begin
        mon_e = rd_q.pop_front();
        check(mon_e.tag, {32'h0, data_rdata}, {32'h0, mon_e.val});
      end
    end
    if (uart_tx_valid && uart_tx_ready) begin
      if (uart_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_uart: got 0x%0h, expected no byte", uart_tx_data);
      end else begin
        mon_b = uart_q.pop_front();
        check("uart_byte", {56'h0, uart_tx_data}, {56'h0, mon_b});
      end
    end
    if (ram_we) begin
      ram_we_cnt++;
      last_wstrb = ram_wstrb;
      last_wdata = ram_wdata;
      last_waddr = ram_waddr;
    end
  end

  task automatic load(input logic [31:0] a, input logic [31:0] exp, input string tag);
    rd_q.push_back('{val: exp, tag: tag});
    data_raddr = a;
    data_re    = 1'b1;
    @(posedge clk); #1;
    data_re    = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    data_waddr = a;
    data_wdata = d;
    data_wstrb = s;
    data_we    = 1'b1;
    @(posedge clk); #1;
    data_we    = 1'b0;
    data_wstrb = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    data_raddr = '0; data_re = 1'b0;
    data_waddr = '0; data_wdata = '0; data_wstrb = '0; data_we = 1'b0;
    uart_tx_ready = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset state
    check("rst_valid", uart_tx_valid, 0);
    check("rst_txdata", uart_tx_data, 0);
    check("rst_irq", timer_irq, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_ram_we", ram_we, 0);
    load(M + 32'h00, 32'h0, "rst_mtime_lo");
    load(M + 32'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
    load(M + 32'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
    load(M + 32'h14, 32'h0000_0002, "rst_status");
    rst = 1'b0;

    // RAM store with partial strobes, then load back
    ram_we_cnt = 0;
    store(32'h0000_0100, 32'hDEAD_BEEF, 4'b0110);
    check("ram_we_count", ram_we_cnt, 1);
    check("ram_wstrb", last_wstrb, 4'b0110);
    check("ram_wdata", last_wdata, 32'hDEAD_BEEF);
    check("ram_waddr", last_waddr, 16'h0100);
    load(32'h0000_0100, 32'h00AD_BE00, "ram_load");

    // FIFO overflow then drain
    for (int i = 0; i < 9; i++) store(M + 32'h10, 32'h41 + i, 4'b0001);
    load(M + 32'h14, 32'h0000_0805, "status_full_ovf");
    check("fifo_head", uart_tx_data, 8'h41);
    for (int i = 0; i < 8; i++) uart_q.push_back(8'(8'h41 + i));
    uart_tx_ready = 1'b1;
    repeat (8) @(posedge clk); #1;
    check("drained_valid", uart_tx_valid, 0);
    check("drained_all", uart_q.size(), 0);
    uart_tx_ready = 1'b0;
    load(M + 32'h14, 32'h0000_0006, "status_empty_ovf");
    store(M + 32'h14, 32'h0000_0004, 4'b0001);
    load(M + 32'h14, 32'h0000_0002, "status_ovf_clr");

    // Timer compare: mtime=0, cmp=10 -> mtime=2 after last store
    store(M + 32'h00, 32'h0, 4'hF);
    store(M + 32'h0C, 32'h0, 4'hF);
    store(M + 32'h08, 32'd10, 4'hF);
    repeat (7) @(posedge clk); #1;
    check("irq_before", timer_irq, 0);
    load(M + 32'h00, 32'd9, "mtime_9");
    check("irq_rise", timer_irq, 1);
    load(M + 32'h00, 32'd10, "mtime_10");
    store(M + 32'h0C, 32'h1, 4'hF);
    check("irq_fall", timer_irq, 0);

    // Carry from lo to hi, and store-on-tick suppression
    store(M + 32'h00, 32'hFFFF_FFFF, 4'hF);
    store(M + 32'h04, 32'h0, 4'hF);
    load(M + 32'h00, 32'hFFFF_FFFF, "mtime_lo_held");
    load(M + 32'h00, 32'h0, "mtime_lo_wrap");
    load(M + 32'h04, 32'h1, "mtime_hi_carry");
    store(M + 32'h00, 32'h0000_1234, 4'hF);
    load(M + 32'h00, 32'h0000_1234, "mtime_store_tick");
    store(M + 32'h00, 32'hAA00_0000, 4'b1000);
    load(M + 32'h00, 32'hAA00_1235, "mtime_strb_merge");
    load(M + 32'h04, 32'h1, "mtime_hi_keep");

    // Unmapped access
    check("bus_err_pre", bus_err, 0);
    we_snap = ram_we_cnt;
    load(32'h2000_0000, 32'h0, "unmapped_load");
    check("bus_err_set", bus_err, 1);
    store(32'h2000_0010, 32'h77, 4'hF);
    repeat (3) @(posedge clk); #1;
    check("bus_err_sticky", bus_err, 1);
    check("unmapped_no_ram", ram_we_cnt, we_snap);
    check("unmapped_no_fifo", uart_tx_valid, 0);

    // Reset mid-operation
    store(M + 32'h0C, 32'h0, 4'hF);
    store(M + 32'h04, 32'h0, 4'hF);
    store(M + 32'h00, 32'd500, 4'hF);
    for (int i = 0; i < 3; i++) store(M + 32'h10, 32'h61 + i, 4'b0001);
    check("pre_rst_valid", uart_tx_valid, 1);
    check("pre_rst_head", uart_tx_data, 8'h61);
    check("pre_rst_irq", timer_irq, 1);
    we_snap = ram_we_cnt;
    rst = 1'b1;
    store(M + 32'h10, 32'h5A, 4'b0001);
    check("mid_rst_valid", uart_tx_valid, 0);
    check("mid_rst_irq", timer_irq, 0);
    check("mid_rst_bus_err", bus_err, 0);
    store(32'h0000_0200, 32'h1111_1111, 4'hF);
    check("rst_no_ram_we", ram_we_cnt, we_snap);
    rst = 1'b0;
    load(M + 32'h00, 32'h0, "post_rst_mtime");
    load(M + 32'h14, 32'h0000_0002, "post_rst_status");
    load(32'h0000_0200, 32'h0, "post_rst_ram");
    check("post_rst_valid", uart_tx_valid, 0);

    @(posedge clk); #1;
    check("load_queue_empty", rd_q.size(), 0);
    check("uart_queue_empty", uart_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
